// File: rtl/clock_ctrl_if.sv
// Signal bundle between the front panel / CPU and clock_ctrl.
// The controller attaches through the slave modport.
interface clock_ctrl_if #(
   parameter int DIV_W = 16
);
   logic [1:0]       mode_sel;
   logic [DIV_W-1:0] div;
   logic             step_btn;
   logic             hlt;
   logic             cpu_clk;
   logic             cpu_ce;
   logic [1:0]       active_mode;
   logic             running;

   modport master (
      output mode_sel, div, step_btn, hlt,
      input  cpu_clk, cpu_ce, active_mode, running
   );

   modport slave (
      input  mode_sel, div, step_btn, hlt,
      output cpu_clk, cpu_ce, active_mode, running
   );
endinterface

// File: rtl/clock_ctrl.sv
// Glitch-free CPU clock generator with RUN / STEP / HALT modes.
// Mode changes are applied only at whole-period boundaries.
module clock_ctrl #(
   parameter int DIV_W           = 16,
   parameter int DEBOUNCE_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rst_n,
   clock_ctrl_if.slave bus
);
   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DEB_ONE  = CNT_W'(1);
   localparam logic [DIV_W-1:0] CNT_ONE  = DIV_W'(1);
   localparam logic [1:0]       MODE_HALT = 2'd0;
   localparam logic [1:0]       MODE_STEP = 2'd1;
   localparam logic [1:0]       MODE_RUN  = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             sync1_q, sync2_q;
   logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
   logic             deb_level_q, deb_level_d;
   logic             step_pend_q, step_pend_d;
   logic [1:0]       active_mode_q, active_mode_d;
   logic             cpu_clk_q, cpu_ce_q, running_q;
   logic             deb_rise_s, boundary_s, go_s, consume_s;
   logic [1:0]       new_mode_s;

   // Debounce: level flips on the DEBOUNCE_CYCLES-th consecutive differing cycle.
   always_comb begin
      deb_cnt_d   = '0;
      deb_level_d = deb_level_q;
      deb_rise_s  = 1'b0;
      if (sync2_q != deb_level_q) begin
         if (deb_cnt_q == DEB_LAST) begin
            deb_level_d = sync2_q;
            deb_rise_s  = sync2_q;
         end else begin
            deb_cnt_d = deb_cnt_q + DEB_ONE;
         end
      end else begin
         deb_cnt_d = '0;
      end
   end

   // Boundary decode, mode capture and step-request bookkeeping.
   always_comb begin
      new_mode_s    = (bus.mode_sel == 2'd3) ? MODE_HALT : bus.mode_sel;
      boundary_s    = (state_q == ST_IDLE) || ((state_q == ST_LOW) && (cnt_q == '0));
      consume_s     = boundary_s && (new_mode_s == MODE_STEP) && step_pend_q;
      go_s          = consume_s || (boundary_s && (new_mode_s == MODE_RUN) && !bus.hlt);
      active_mode_d = boundary_s ? new_mode_s : active_mode_q;
      if (consume_s || (boundary_s && (new_mode_s != MODE_STEP))) begin
         step_pend_d = 1'b0;
      end else begin
         step_pend_d = step_pend_q | deb_rise_s;
      end
   end

   // Period FSM: the half-period count reloads from div only on entry to a phase.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (go_s) begin
               state_d = ST_HIGH;
               cnt_d   = bus.div;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_HIGH: begin
            if (cnt_q == '0) begin
               state_d = ST_LOW;
               cnt_d   = bus.div;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_LOW: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_ONE;
            end else if (go_s) begin
               state_d = ST_HIGH;
               cnt_d   = bus.div;
            end else begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Step button synchroniser and debounce state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         deb_cnt_q   <= '0;
         deb_level_q <= 1'b0;
      end else begin
         sync1_q     <= bus.step_btn;
         sync2_q     <= sync1_q;
         deb_cnt_q   <= deb_cnt_d;
         deb_level_q <= deb_level_d;
      end
   end

   // FSM state, counters and registered outputs derived from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         step_pend_q   <= 1'b0;
         active_mode_q <= MODE_HALT;
         cpu_clk_q     <= 1'b0;
         cpu_ce_q      <= 1'b0;
         running_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         step_pend_q   <= step_pend_d;
         active_mode_q <= active_mode_d;
         cpu_clk_q     <= (state_d == ST_HIGH);
         cpu_ce_q      <= (state_d == ST_HIGH) && (state_q != ST_HIGH);
         running_q     <= (state_d != ST_IDLE);
      end
   end

   assign bus.cpu_clk     = cpu_clk_q;
   assign bus.cpu_ce      = cpu_ce_q;
   assign bus.active_mode = active_mode_q;
   assign bus.running     = running_q;
endmodule

// File: tb/tb_clock_ctrl.sv
// Self-checking bench for clock_ctrl: table of steady-mode vectors plus
// hand-built sequences for mode/hlt/div/reset/step corner cases.
module tb_clock_ctrl;
   localparam int DIV_W = 16;
   localparam int DEB   = 4;

   typedef struct packed {
      logic       clk_v;
      logic       ce_v;
      logic       run_v;
      logic [1:0] mode_v;
   } exp_t;

   typedef struct {
      logic [1:0]       mode_sel;
      logic [DIV_W-1:0] div;
      logic             hlt;
      int               cycles;
      logic [1:0]       exp_mode;
      logic             exp_toggle;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   clock_ctrl_if #(.DIV_W(DIV_W)) bus ();
   clock_ctrl #(.DIV_W(DIV_W), .DEBOUNCE_CYCLES(DEB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   vec_t vecs[7];

   function automatic exp_t mk(logic c, logic e, logic r, logic [1:0] m);
      exp_t x;
      x.clk_v  = c;
      x.ce_v   = e;
      x.run_v  = r;
      x.mode_v = m;
      return x;
   endfunction

   task automatic compare(string name, exp_t want);
      exp_t got;
      got = {bus.cpu_clk, bus.cpu_ce, bus.running, bus.active_mode};
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s @%0t: got clk=%0b ce=%0b run=%0b mode=%0d, want clk=%0b ce=%0b run=%0b mode=%0d",
                  name, $time, got.clk_v, got.ce_v, got.run_v, got.mode_v,
                  want.clk_v, want.ce_v, want.run_v, want.mode_v);
      end
   endtask

   task automatic check_sample(string name);
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s @%0t: no expectation queued", name, $time);
      end else begin
         compare(name, exp_q.pop_front());
      end
   endtask

   task automatic check_cycle(string name);
      @(negedge clk);
      check_sample(name);
   endtask

   task automatic push_period(int d, int nper, logic [1:0] m);
      for (int p = 0; p < nper; p++) begin
         for (int i = 0; i <= d; i++) exp_q.push_back(mk(1'b1, (i == 0), 1'b1, m));
         for (int i = 0; i <= d; i++) exp_q.push_back(mk(1'b0, 1'b0, 1'b1, m));
      end
   endtask

   task automatic push_idle(int n, logic [1:0] m);
      for (int i = 0; i < n; i++) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, m));
   endtask

   task automatic do_reset(logic [1:0] m, logic [DIV_W-1:0] d, logic h);
      @(negedge clk);
      rst_n        = 1'b0;
      bus.mode_sel = m;
      bus.div      = d;
      bus.hlt      = h;
      bus.step_btn = 1'b0;
      exp_q.delete();
      @(negedge clk);
      compare("reset_state", mk(1'b0, 1'b0, 1'b0, 2'd0));
      rst_n = 1'b1;
   endtask

   // Waits for cpu_clk high; returns the number of negedges waited.
   task automatic wait_rise(int limit, string name, output int waited);
      waited = 0;
      n_cmp++;
      while (1) begin
         @(negedge clk);
         waited++;
         if (bus.cpu_clk === 1'b1) break;
         if (waited >= limit) begin
            n_bad++;
            $display("FAIL %s: cpu_clk never rose, got 0 after %0d cycles, want 1", name, waited);
            break;
         end
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      bus.mode_sel = 2'd0;
      bus.div      = '0;
      bus.hlt      = 1'b0;
      bus.step_btn = 1'b0;

      vecs[0] = '{2'd2, 16'd3,      1'b0, 24, 2'd2, 1'b1};
      vecs[1] = '{2'd2, 16'd0,      1'b0, 10, 2'd2, 1'b1};
      vecs[2] = '{2'd0, 16'd4,      1'b0,  8, 2'd0, 1'b0};
      vecs[3] = '{2'd3, 16'd2,      1'b0,  8, 2'd0, 1'b0};
      vecs[4] = '{2'd2, 16'd1,      1'b1,  8, 2'd2, 1'b0};
      vecs[5] = '{2'd1, 16'd2,      1'b0,  8, 2'd1, 1'b0};
      vecs[6] = '{2'd2, 16'hFFFF,   1'b0, 20, 2'd2, 1'b1};

      // Steady-mode vectors: expected waveform from the period formula.
      foreach (vecs[v]) begin
         int d1;
         do_reset(vecs[v].mode_sel, vecs[v].div, vecs[v].hlt);
         d1 = int'(vecs[v].div) + 1;
         for (int k = 0; k < vecs[v].cycles; k++) begin
            logic c;
            c = vecs[v].exp_toggle && (((k / d1) % 2) == 0);
            exp_q.push_back(mk(c, c && ((k % d1) == 0), vecs[v].exp_toggle, vecs[v].exp_mode));
            check_cycle($sformatf("vec%0d_k%0d", v, k));
         end
      end

      // Bouncy press in STEP, div=1: exactly one period, then idle.
      do_reset(2'd1, 16'd1, 1'b0);
      push_idle(3, 2'd1);
      for (int k = 0; k < 3; k++) check_cycle("step_idle");
      for (int i = 0; i < 10; i++) begin
         bus.step_btn = (((i / 2) % 2) == 0);
         push_idle(1, 2'd1);
         check_cycle("step_bounce");
      end
      bus.step_btn = 1'b1;
      wait_rise(20, "step_rise", w);
      push_period(1, 1, 2'd1);
      push_idle(8, 2'd1);
      check_sample("step_period");
      while (exp_q.size() > 0) check_cycle("step_period");

      // Clean press latency, then a second press during the period runs back-to-back.
      do_reset(2'd1, 16'd7, 1'b0);
      push_idle(2, 2'd1);
      check_cycle("b2b_idle");
      check_cycle("b2b_idle");
      bus.step_btn = 1'b1;
      push_idle(6, 2'd1);
      for (int k = 0; k < 6; k++) check_cycle("step_latency");
      push_period(7, 2, 2'd1);
      push_idle(4, 2'd1);
      check_cycle("step_latency_rise");
      bus.step_btn = 1'b0;
      for (int j = 1; exp_q.size() > 0; j++) begin
         check_cycle($sformatf("b2b_j%0d", j));
         if (j == 8) bus.step_btn = 1'b1;
      end
      bus.step_btn = 1'b0;

      // Mode change to HALT inside HIGH: full period completes, mode updates at end.
      do_reset(2'd2, 16'd5, 1'b0);
      push_period(5, 1, 2'd2);
      push_idle(4, 2'd0);
      for (int k = 0; exp_q.size() > 0; k++) begin
         check_cycle($sformatf("halt_mid_k%0d", k));
         if (k == 1) bus.mode_sel = 2'd0;
      end

      // hlt raised mid-LOW, released later: restart one cycle after release.
      do_reset(2'd2, 16'd2, 1'b0);
      push_period(2, 1, 2'd2);
      push_idle(4, 2'd2);
      push_period(2, 1, 2'd2);
      for (int k = 0; exp_q.size() > 0; k++) begin
         check_cycle($sformatf("hlt_k%0d", k));
         if (k == 4) bus.hlt = 1'b1;
         if (k == 9) bus.hlt = 1'b0;
      end

      // div=0 toggling, then div changed mid-HIGH affects only the next phase.
      do_reset(2'd2, 16'd0, 1'b0);
      push_period(0, 2, 2'd2);
      exp_q.push_back(mk(1'b1, 1'b1, 1'b1, 2'd2));
      for (int i = 0; i < 3; i++) exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 2'd2));
      push_period(2, 1, 2'd2);
      for (int k = 0; exp_q.size() > 0; k++) begin
         check_cycle($sformatf("div_chg_k%0d", k));
         if (k == 4) bus.div = 16'd2;
      end

      // Asynchronous reset mid-HIGH, then restart from IDLE.
      do_reset(2'd2, 16'd7, 1'b0);
      push_period(7, 1, 2'd2);
      for (int k = 0; k < 4; k++) check_cycle("pre_reset");
      rst_n = 1'b0;
      #1;
      compare("async_reset", mk(1'b0, 1'b0, 1'b0, 2'd0));
      @(negedge clk);
      compare("reset_hold", mk(1'b0, 1'b0, 1'b0, 2'd0));
      rst_n = 1'b1;
      exp_q.delete();
      push_period(7, 1, 2'd2);
      for (int k = 0; k < 10; k++) check_cycle($sformatf("post_reset_k%0d", k));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
